conv1x1_engine: RTL and testbench
=================================

Name: conv1x1_engine

Overview:
Sequential pointwise (1x1) convolution with optional spatial stride, used in the residual datapath for channel expansion and projection shortcuts. It takes a flat signed CHW tensor, per-(out,in) channel weights and per-output-channel bias. It produces a flat signed output tensor, computing one output element per cycle under a level start/done handshake.

Parameters:
DATA_WIDTH, 8, bit width of every signed element, weight and bias.
IN_CHANNELS, 1, input channel count.
OUT_CHANNELS, 1, output channel count.
IN_HEIGHT, 4, input rows.
IN_WIDTH, 4, input columns.
STRIDE, 1, spatial stride (>=1). Derived: OUT_H=(IN_HEIGHT-1)/STRIDE+1, OUT_W=(IN_WIDTH-1)/STRIDE+1, N_OUT=OUT_CHANNELS*OUT_H*OUT_W.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  level request; held high by the master until done is seen.
done  out  1  high while in DONE state.
input_tensor_flat  in  DATA_WIDTH*IN_CHANNELS*IN_HEIGHT*IN_WIDTH  signed elements; element (c,r,x) at index (c*IN_HEIGHT+r)*IN_WIDTH+x, bits [idx*DATA_WIDTH +: DATA_WIDTH].
weights_flat  in  DATA_WIDTH*OUT_CHANNELS*IN_CHANNELS  signed weight (o,i) at index o*IN_CHANNELS+i.
bias_flat  in  DATA_WIDTH*OUT_CHANNELS  signed bias o at index o.
output_tensor_flat  out  DATA_WIDTH*N_OUT  signed result (o,r,x) at index (o*OUT_H+r)*OUT_W+x; registered.

Behaviour:
- Reset (async): state IDLE, done=0, element counter=0, output_tensor_flat=0.
- States: IDLE, COMPUTE, DONE.
- IDLE: start=1 at a clock edge is the accept edge. Capture input tensor, weights and bias into internal registers. Go to COMPUTE with counter=0. Otherwise stay in IDLE.
- COMPUTE: each cycle produces output element idx=counter. Decode (o,r,x). Source pixel is (r*STRIDE, x*STRIDE).
- Per element: acc = bias[o] + sum over i of w[o,i]*in[i, r*STRIDE, x*STRIDE].
- acc is full-precision signed: width >= 2*DATA_WIDTH + clog2(IN_CHANNELS+1) + 1. No fractional shift (integer arithmetic).
- Result saturates to the signed DATA_WIDTH range: [-2^(DW-1), 2^(DW-1)-1], i.e. [-128, 127] at default.
- The element register is written at the edge ending the cycle. The counter increments. On idx=N_OUT-1 the state goes to DONE.
- Latency: done rises N_OUT cycles after the accept edge. All outputs are valid when done is high.
- start dropping during COMPUTE does not abort; computation completes.
- DONE: done=1 (decoded from state). Stay while start=1. When start=0 at an edge, go to IDLE; done falls.
- If start is already low on entering DONE, done is high for exactly one cycle.
- output_tensor_flat holds its value after DONE until overwritten by the next operation. Elements are overwritten progressively during the next COMPUTE.
- Inputs may change after the accept edge without affecting the result.
- Reset mid-operation: immediate abort to IDLE. Outputs are zeroed, done=0, and no partial result is retained.
- Re-accept requires passing through IDLE: start must be seen low in DONE first.

Test Plan:
- Identity, defaults (1ch 4x4): weight=1, bias=0, input element k=k (0..15), start held -> done rises 16 cycles after accept edge; output element k = k.
- Arithmetic/saturation, 1ch: w=2, b=3, in=10 -> 23. w=127, b=0, in=100 -> 127 (clip). w=-128, in=100 -> -128 (clip). w=-1, b=-5, in=7 -> -12.
- Multi-channel, IN=2, OUT=2, 2x2: w[0]={1,1}, w[1]={1,-1}, b={0,10}, ch0 all 5, ch1 all 3 -> out ch0 all 8, out ch1 all 12; done after 8 cycles.
- Stride 2 on 4x4, 1ch: in element k=k, w=1, b=0 -> 2x2 output {0,2,8,10}; done after 4 cycles.
- Handshake: hold start 5 cycles past done -> done stays 1 and output is stable. Drop start -> done=0 after next edge, output retained. Restart with new inputs -> new results.
- Reset mid-COMPUTE (assert rst at cycle 6 of 16) -> done=0 and output all zeros immediately. After release and new start, a full correct result arrives 16 cycles later.

Source files
------------

// File: rtl/conv1x1_engine.sv
// -----------------------------------------------------------------------------
// conv1x1_engine
//
// Sequential pointwise (1x1) convolution with optional spatial stride. Used in
// the residual datapath for channel expansion and projection shortcuts.
//
// One output element is produced per cycle. Operands are captured on the
// accept edge. Each result is the saturated sum
//   bias[o] + sum_i w[o,i] * in[i, r*STRIDE, x*STRIDE].
//
// Ports:
//   clk                 rising-edge clock
//   rst                 asynchronous, active-high reset
//   start               level request, held by the master until done is seen
//   done                high while the result is complete (DONE state)
//   input_tensor_flat   signed CHW tensor; (c,r,x) at (c*IN_HEIGHT+r)*IN_WIDTH+x
//   weights_flat        signed weights; (o,i) at o*IN_CHANNELS+i
//   bias_flat           signed per-output-channel bias; o at o
//   output_tensor_flat  registered signed result; (o,r,x) at (o*OUT_H+r)*OUT_W+x
// -----------------------------------------------------------------------------
module conv1x1_engine #(
  parameter int DATA_WIDTH   = 8,
  parameter int IN_CHANNELS  = 1,
  parameter int OUT_CHANNELS = 1,
  parameter int IN_HEIGHT    = 4,
  parameter int IN_WIDTH     = 4,
  parameter int STRIDE       = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic done,
  input  logic [DATA_WIDTH*IN_CHANNELS*IN_HEIGHT*IN_WIDTH-1:0] input_tensor_flat,
  input  logic [DATA_WIDTH*OUT_CHANNELS*IN_CHANNELS-1:0]       weights_flat,
  input  logic [DATA_WIDTH*OUT_CHANNELS-1:0]                   bias_flat,
  output logic [DATA_WIDTH*OUT_CHANNELS*((IN_HEIGHT-1)/STRIDE+1)*((IN_WIDTH-1)/STRIDE+1)-1:0]
               output_tensor_flat
);

  localparam int OUT_H = (IN_HEIGHT - 1) / STRIDE + 1;
  localparam int OUT_W = (IN_WIDTH - 1) / STRIDE + 1;
  localparam int PLANE = OUT_H * OUT_W;
  localparam int N_OUT = OUT_CHANNELS * PLANE;
  localparam int N_IN  = IN_CHANNELS * IN_HEIGHT * IN_WIDTH;
  localparam int N_W   = OUT_CHANNELS * IN_CHANNELS;

  // Wide enough that no sum of products plus bias can wrap before saturation.
  localparam int ACC_W = 2 * DATA_WIDTH + $clog2(IN_CHANNELS + 1) + 1;

  localparam int CNT_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int IN_AW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int W_AW  = (N_W > 1) ? $clog2(N_W) : 1;
  localparam int B_AW  = (OUT_CHANNELS > 1) ? $clog2(OUT_CHANNELS) : 1;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (DATA_WIDTH - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMPUTE,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0] cnt_q;
  logic             accept;
  logic             last_elem;

  logic signed [DATA_WIDTH-1:0] in_mem  [N_IN];
  logic signed [DATA_WIDTH-1:0] w_mem   [N_W];
  logic signed [DATA_WIDTH-1:0] b_mem   [OUT_CHANNELS];
  logic signed [DATA_WIDTH-1:0] out_mem [N_OUT];

  int                           elem_o;
  int                           elem_r;
  int                           elem_x;
  logic signed [ACC_W-1:0]      acc;
  logic signed [DATA_WIDTH-1:0] sat;

  assign last_elem = (cnt_q == CNT_W'(N_OUT - 1));
  assign done      = (state_q == S_DONE);

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every output of this block is given a default before the case, so
  // no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = S_COMPUTE;
        end
      end
      // start is deliberately ignored here: a request is never aborted.
      S_COMPUTE: if (last_elem) state_d = S_DONE;
      S_DONE:    if (!start)    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Element counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= '0;
    end else if (state_q == S_COMPUTE) begin
      cnt_q <= last_elem ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Operand capture. The master may change its inputs after the accept edge.
  // ---------------------------------------------------------------------------
  // NOTE: these stores have no reset on purpose. They are only read in
  // COMPUTE, which is reachable only through an accept edge that fills them.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < N_IN; k++)
        in_mem[k] <= input_tensor_flat[k*DATA_WIDTH +: DATA_WIDTH];
      for (int k = 0; k < N_W; k++)
        w_mem[k] <= weights_flat[k*DATA_WIDTH +: DATA_WIDTH];
      for (int k = 0; k < OUT_CHANNELS; k++)
        b_mem[k] <= bias_flat[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: decode counter -> (o,r,x), then MAC over input channels.
  // ---------------------------------------------------------------------------
  // NOTE: blocking assignments are correct here. acc is a running sum inside
  // one combinational evaluation, and each iteration must see the previous
  // partial value.
  always_comb begin
    elem_o = int'(cnt_q) / PLANE;
    elem_r = (int'(cnt_q) % PLANE) / OUT_W;
    elem_x = (int'(cnt_q) % PLANE) % OUT_W;

    acc = ACC_W'(b_mem[B_AW'(elem_o)]);
    for (int i = 0; i < IN_CHANNELS; i++) begin
      acc = acc
          + ACC_W'(w_mem[W_AW'(elem_o * IN_CHANNELS + i)])
          * ACC_W'(in_mem[IN_AW'((i * IN_HEIGHT + elem_r * STRIDE) * IN_WIDTH
                                 + elem_x * STRIDE)]);
    end

    if (acc > SAT_MAX)      sat = SAT_MAX[DATA_WIDTH-1:0];
    else if (acc < SAT_MIN) sat = SAT_MIN[DATA_WIDTH-1:0];
    else                    sat = acc[DATA_WIDTH-1:0];
  end

  // ---------------------------------------------------------------------------
  // Result store. It is cleared by reset so that an aborted run leaves nothing
  // behind. Otherwise it is overwritten element by element during COMPUTE.
  // ---------------------------------------------------------------------------
  // NOTE: this array needs a reset because its contents are visible on a
  // port and must read zero after reset. The operand stores above do not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_OUT; k++) out_mem[k] <= '0;
    end else if (state_q == S_COMPUTE) begin
      out_mem[cnt_q] <= sat;
    end
  end

  for (genvar g = 0; g < N_OUT; g++) begin : g_flat
    assign output_tensor_flat[g*DATA_WIDTH +: DATA_WIDTH] = out_mem[g];
  end

endmodule

// File: tb/tb_conv1x1_engine.sv
// -----------------------------------------------------------------------------
// tb_conv1x1_engine
//
// Three engine instances:
//   dut_a  default parameters (1 channel, 4x4, stride 1)
//   dut_b  2 in / 2 out channels, 2x2
//   dut_b's sibling dut_c  1 channel, 4x4, stride 2
//
// Each stimulus task pushes the reference-model result and the expected done
// cycle into per-instance queues. A per-instance monitor pops and compares on
// every rising edge of done.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_conv1x1_engine;

  localparam int DW = 8;
  typedef int int_q_t[$];

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input int actual, input int expected);
    n_total++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Reference model: plain integer arithmetic over the CHW layout, then clip.
  // ---------------------------------------------------------------------------
  function automatic int clip8(input longint v);
    if (v > 127)  return 127;
    if (v < -128) return -128;
    return int'(v);
  endfunction

  function automatic int_q_t ref_conv(input int ic, input int oc, input int ih,
                                      input int iw, input int st,
                                      input int_q_t in_v, input int_q_t w_v,
                                      input int_q_t b_v);
    int_q_t res;
    int oh = (ih - 1) / st + 1;
    int ow = (iw - 1) / st + 1;
    for (int o = 0; o < oc; o++)
      for (int r = 0; r < oh; r++)
        for (int x = 0; x < ow; x++) begin
          longint sum = longint'(b_v[o]);
          for (int i = 0; i < ic; i++)
            sum += longint'(w_v[o*ic + i]) * longint'(in_v[(i*ih + r*st)*iw + x*st]);
          res.push_back(clip8(sum));
        end
    return res;
  endfunction

  function automatic int rnd8();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  function automatic int_q_t rand_q(input int n);
    int_q_t q;
    for (int k = 0; k < n; k++) q.push_back(rnd8());
    return q;
  endfunction

  // ---------------------------------------------------------------------------
  // DUT A: defaults
  // ---------------------------------------------------------------------------
  localparam int A_IN = 16, A_OUT = 16;
  logic              start_a, done_a;
  logic [DW*A_IN-1:0]  in_a;
  logic [DW-1:0]       w_a, b_a;
  logic [DW*A_OUT-1:0] out_a;
  int_q_t exp_a, lat_a;

  conv1x1_engine dut_a (
    .clk(clk), .rst(rst), .start(start_a), .done(done_a),
    .input_tensor_flat(in_a), .weights_flat(w_a), .bias_flat(b_a),
    .output_tensor_flat(out_a)
  );

  function automatic int get_a(input int k);
    return int'($signed(out_a[k*DW +: DW]));
  endfunction

  // ---------------------------------------------------------------------------
  // DUT B: 2 in, 2 out, 2x2
  // ---------------------------------------------------------------------------
  localparam int B_IN = 8, B_W = 4, B_B = 2, B_OUT = 8;
  logic               start_b, done_b;
  logic [DW*B_IN-1:0]  in_b;
  logic [DW*B_W-1:0]   w_b;
  logic [DW*B_B-1:0]   b_b;
  logic [DW*B_OUT-1:0] out_b;
  int_q_t exp_b, lat_b;

  conv1x1_engine #(
    .DATA_WIDTH(DW), .IN_CHANNELS(2), .OUT_CHANNELS(2),
    .IN_HEIGHT(2), .IN_WIDTH(2), .STRIDE(1)
  ) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .done(done_b),
    .input_tensor_flat(in_b), .weights_flat(w_b), .bias_flat(b_b),
    .output_tensor_flat(out_b)
  );

  function automatic int get_b(input int k);
    return int'($signed(out_b[k*DW +: DW]));
  endfunction

  // ---------------------------------------------------------------------------
  // DUT C: 1 channel, 4x4, stride 2
  // ---------------------------------------------------------------------------
  localparam int C_IN = 16, C_OUT = 4;
  logic              start_c, done_c;
  logic [DW*C_IN-1:0]  in_c;
  logic [DW-1:0]       w_c, b_c;
  logic [DW*C_OUT-1:0] out_c;
  int_q_t exp_c, lat_c;

  conv1x1_engine #(
    .DATA_WIDTH(DW), .IN_CHANNELS(1), .OUT_CHANNELS(1),
    .IN_HEIGHT(4), .IN_WIDTH(4), .STRIDE(2)
  ) dut_c (
    .clk(clk), .rst(rst), .start(start_c), .done(done_c),
    .input_tensor_flat(in_c), .weights_flat(w_c), .bias_flat(b_c),
    .output_tensor_flat(out_c)
  );

  function automatic int get_c(input int k);
    return int'($signed(out_c[k*DW +: DW]));
  endfunction

  // ---------------------------------------------------------------------------
  // Monitors: on each rising edge of done, check latency and every element.
  // ---------------------------------------------------------------------------
  logic done_a_prev = 1'b0, done_b_prev = 1'b0, done_c_prev = 1'b0;

  always @(negedge clk) begin
    if (done_a && !done_a_prev) begin
      if (lat_a.size() == 0) begin
        n_total++;
        $display("FAIL a_unexpected_done: done rose with no pending request (cycle %0d)", cyc);
      end else begin
        check("a_latency", cyc, lat_a.pop_front());
        for (int k = 0; k < A_OUT; k++)
          check($sformatf("a_out[%0d]", k), get_a(k), exp_a.pop_front());
      end
    end
    done_a_prev = done_a;
  end

  always @(negedge clk) begin
    if (done_b && !done_b_prev) begin
      if (lat_b.size() == 0) begin
        n_total++;
        $display("FAIL b_unexpected_done: done rose with no pending request (cycle %0d)", cyc);
      end else begin
        check("b_latency", cyc, lat_b.pop_front());
        for (int k = 0; k < B_OUT; k++)
          check($sformatf("b_out[%0d]", k), get_b(k), exp_b.pop_front());
      end
    end
    done_b_prev = done_b;
  end

  always @(negedge clk) begin
    if (done_c && !done_c_prev) begin
      if (lat_c.size() == 0) begin
        n_total++;
        $display("FAIL c_unexpected_done: done rose with no pending request (cycle %0d)", cyc);
      end else begin
        check("c_latency", cyc, lat_c.pop_front());
        for (int k = 0; k < C_OUT; k++)
          check($sformatf("c_out[%0d]", k), get_c(k), exp_c.pop_front());
      end
    end
    done_c_prev = done_c;
  end

  // ---------------------------------------------------------------------------
  // Stimulus tasks
  // ---------------------------------------------------------------------------
  task automatic check_out_a(input string tag, input int_q_t e);
    for (int k = 0; k < A_OUT; k++)
      check($sformatf("%s[%0d]", tag, k), get_a(k), e[k]);
  endtask

  // hold: cycles to keep start high after done is seen.
  // drop_early: release start right after the accept edge.
  task automatic run_a(input int_q_t in_v, input int w, input int b,
                       input int hold, input bit drop_early);
    int_q_t e, wq, bq;
    int t;
    wq.push_back(w);
    bq.push_back(b);
    e = ref_conv(1, 1, 4, 4, 1, in_v, wq, bq);
    @(negedge clk);
    for (int k = 0; k < A_IN; k++) in_a[k*DW +: DW] = DW'(in_v[k]);
    w_a = DW'(w);
    b_a = DW'(b);
    start_a = 1'b1;
    foreach (e[k]) exp_a.push_back(e[k]);
    lat_a.push_back(cyc + 1 + A_OUT);
    @(negedge clk);
    // Accept edge has passed: scrambled inputs must not affect the result.
    for (int k = 0; k < A_IN; k++) in_a[k*DW +: DW] = DW'($urandom);
    w_a = DW'($urandom);
    b_a = DW'($urandom);
    if (drop_early) start_a = 1'b0;
    t = 0;
    while (!done_a && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!done_a) begin
      n_total++;
      $display("FAIL a_done_timeout: done=%0d after %0d cycles, expected 1", done_a, t);
      start_a = 1'b0;
      return;
    end
    if (drop_early) begin
      @(negedge clk);
      check("a_done_one_cycle", done_a, 0);
      check_out_a("a_retain_early", e);
    end else begin
      repeat (hold) begin
        @(negedge clk);
        check("a_done_held", done_a, 1);
        check_out_a("a_stable", e);
      end
      start_a = 1'b0;
      @(negedge clk);
      check("a_done_fall", done_a, 0);
      check_out_a("a_retain", e);
    end
  endtask

  task automatic reset_mid_a(input int_q_t in_v, input int w, input int b);
    @(negedge clk);
    for (int k = 0; k < A_IN; k++) in_a[k*DW +: DW] = DW'(in_v[k]);
    w_a = DW'(w);
    b_a = DW'(b);
    start_a = 1'b1;
    @(negedge clk);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("a_rst_mid_done", done_a, 0);
    for (int k = 0; k < A_OUT; k++)
      check($sformatf("a_rst_mid_out[%0d]", k), get_a(k), 0);
    start_a = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_b(input int_q_t in_v, input int_q_t w_v, input int_q_t b_v);
    int_q_t e;
    int t;
    e = ref_conv(2, 2, 2, 2, 1, in_v, w_v, b_v);
    @(negedge clk);
    for (int k = 0; k < B_IN; k++) in_b[k*DW +: DW] = DW'(in_v[k]);
    for (int k = 0; k < B_W; k++)  w_b[k*DW +: DW]  = DW'(w_v[k]);
    for (int k = 0; k < B_B; k++)  b_b[k*DW +: DW]  = DW'(b_v[k]);
    start_b = 1'b1;
    foreach (e[k]) exp_b.push_back(e[k]);
    lat_b.push_back(cyc + 1 + B_OUT);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!done_b && t < 100);
    if (!done_b) begin
      n_total++;
      $display("FAIL b_done_timeout: done=%0d after %0d cycles, expected 1", done_b, t);
    end
    start_b = 1'b0;
    @(negedge clk);
    check("b_done_fall", done_b, 0);
  endtask

  task automatic run_c(input int_q_t in_v, input int w, input int b);
    int_q_t e, wq, bq;
    int t;
    wq.push_back(w);
    bq.push_back(b);
    e = ref_conv(1, 1, 4, 4, 2, in_v, wq, bq);
    @(negedge clk);
    for (int k = 0; k < C_IN; k++) in_c[k*DW +: DW] = DW'(in_v[k]);
    w_c = DW'(w);
    b_c = DW'(b);
    start_c = 1'b1;
    foreach (e[k]) exp_c.push_back(e[k]);
    lat_c.push_back(cyc + 1 + C_OUT);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!done_c && t < 100);
    if (!done_c) begin
      n_total++;
      $display("FAIL c_done_timeout: done=%0d after %0d cycles, expected 1", done_c, t);
    end
    start_c = 1'b0;
    @(negedge clk);
    check("c_done_fall", done_c, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int_q_t v, wq, bq;
    rst = 1'b1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    in_a = '0; w_a = '0; b_a = '0;
    in_b = '0; w_b = '0; b_b = '0;
    in_c = '0; w_c = '0; b_c = '0;
    repeat (2) @(negedge clk);
    check("rst_done_a", done_a, 0);
    check("rst_done_b", done_b, 0);
    check("rst_done_c", done_c, 0);
    for (int k = 0; k < A_OUT; k++) check($sformatf("rst_out_a[%0d]", k), get_a(k), 0);
    rst = 1'b0;

    // Identity: output element k = k.
    v.delete();
    for (int k = 0; k < 16; k++) v.push_back(k);
    run_a(v, 1, 0, 0, 1'b0);
    check("ident_elem15", get_a(15), 15);

    // Arithmetic and saturation on element 0.
    v = rand_q(16);
    v[0] = 10;  run_a(v, 2, 3, 0, 1'b0);     check("arith_23", get_a(0), 23);
    v[0] = 100; run_a(v, 127, 0, 0, 1'b0);   check("sat_pos", get_a(0), 127);
    v[0] = 100; run_a(v, -128, 0, 0, 1'b0);  check("sat_neg", get_a(0), -128);
    v[0] = 7;   run_a(v, -1, -5, 0, 1'b0);   check("arith_m12", get_a(0), -12);

    // Handshake: hold start past done, then a start that drops during COMPUTE.
    run_a(rand_q(16), rnd8(), rnd8(), 5, 1'b0);
    run_a(rand_q(16), rnd8(), rnd8(), 0, 1'b1);

    // Reset in the middle of COMPUTE, then a full run.
    reset_mid_a(rand_q(16), rnd8(), rnd8());
    v.delete();
    for (int k = 0; k < 16; k++) v.push_back(15 - k);
    run_a(v, 3, -7, 0, 1'b0);

    repeat (4) run_a(rand_q(16), rnd8(), rnd8(), int'($urandom_range(0, 2)),
                     1'(($urandom_range(0, 1))));

    // Multi-channel case with known results.
    v.delete(); wq.delete(); bq.delete();
    for (int k = 0; k < 4; k++) v.push_back(5);
    for (int k = 0; k < 4; k++) v.push_back(3);
    wq.push_back(1); wq.push_back(1); wq.push_back(1); wq.push_back(-1);
    bq.push_back(0); bq.push_back(10);
    run_b(v, wq, bq);
    check("mc_ch0", get_b(0), 8);
    check("mc_ch1", get_b(7), 12);
    repeat (5) run_b(rand_q(8), rand_q(4), rand_q(2));

    // Stride 2 with known results.
    v.delete();
    for (int k = 0; k < 16; k++) v.push_back(k);
    run_c(v, 1, 0);
    check("stride_1", get_c(1), 2);
    check("stride_2", get_c(2), 8);
    check("stride_3", get_c(3), 10);
    repeat (5) run_c(rand_q(16), rnd8(), rnd8());

    repeat (3) @(negedge clk);
    check("sb_a_drained", exp_a.size() + lat_a.size(), 0);
    check("sb_b_drained", exp_b.size() + lat_b.size(), 0);
    check("sb_c_drained", exp_c.size() + lat_c.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
